// File: rtl/rca_seq_add_ctrl.sv
// Two-requester round-robin scheduler sharing one WORD-bit ripple-carry slice
// for WORD*NWORDS-bit additions, LSW first. Optional RCA_SEQ_ADD_SIGNED_OVF_EN adds res_ovf.
module rca_seq_add_ctrl #(
  parameter int unsigned WORD   = 12,
  parameter int unsigned NWORDS = 4,
  localparam int unsigned WIDTH = WORD * NWORDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_sum,
  output logic             res_id,
  output logic             busy
`ifdef RCA_SEQ_ADD_SIGNED_OVF_EN
  ,
  output logic             res_ovf
`endif
);

  localparam int unsigned IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             prio;       // requester that wins a tie
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic             id_reg;
  logic             res_valid_r;
  logic             busy_r;

  logic             grant_any;
  logic             grant_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  logic [WORD-1:0]  a_word;
  logic [WORD-1:0]  b_word;
  logic [WORD-1:0]  s_word;
  logic [WORD:0]    chain;
  logic             c_out;

  always_comb begin
    grant_any = req0_valid || req1_valid;
    grant_id  = (req0_valid && req1_valid) ? prio : req1_valid;
    sel_a     = grant_id ? req1_a : req0_a;
    sel_b     = grant_id ? req1_b : req0_b;
  end

  assign req0_ready = (state == IDLE) && grant_any && !grant_id;
  assign req1_ready = (state == IDLE) && grant_any &&  grant_id;

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int unsigned w = 0; w < NWORDS; w++) begin
      if (idx == IDXW'(w)) begin
        a_word = a_reg[w*WORD +: WORD];
        b_word = b_reg[w*WORD +: WORD];
      end
    end
  end

  // Shared slice: explicit full-adder chain seeded by the inter-word carry.
  always_comb begin
    chain    = '0;
    s_word   = '0;
    chain[0] = carry;
    for (int unsigned i = 0; i < WORD; i++) begin
      s_word[i]  = a_word[i] ^ b_word[i] ^ chain[i];
      chain[i+1] = (a_word[i] & b_word[i]) | (chain[i] & (a_word[i] ^ b_word[i]));
    end
    c_out = chain[WORD];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prio        <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      sum_reg     <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      id_reg      <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef RCA_SEQ_ADD_SIGNED_OVF_EN
      res_ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            a_reg   <= sel_a;
            b_reg   <= sel_b;
            id_reg  <= grant_id;
            prio    <= !grant_id;
            carry   <= 1'b0;
            idx     <= '0;
            busy_r  <= 1'b1;
            state   <= RUN;
`ifdef RCA_SEQ_ADD_SIGNED_OVF_EN
            res_ovf <= 1'b0;
`endif
          end
        end
        RUN: begin
          for (int unsigned w = 0; w < NWORDS; w++) begin
            if (idx == IDXW'(w)) sum_reg[w*WORD +: WORD] <= s_word;
          end
          carry <= c_out;
          if (idx == LAST_IDX) begin
            state       <= DONE;
            res_valid_r <= 1'b1;
`ifdef RCA_SEQ_ADD_SIGNED_OVF_EN
            res_ovf     <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                           (s_word[WORD-1] != a_reg[WIDTH-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state       <= IDLE;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_r;
  assign res_sum   = {carry, sum_reg};
  assign res_id    = id_reg;
  assign busy      = busy_r;

endmodule

// File: tb/tb_rca_seq_add_ctrl.sv
// Scoreboard bench for rca_seq_add_ctrl: randomized requests against a
// transaction-level model of arbitration, latency and A+B results.
module tb_rca_seq_add_ctrl;
  localparam int unsigned WORD   = 12;
  localparam int unsigned NWORDS = 4;
  localparam int unsigned WIDTH  = WORD * NWORDS;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  typedef struct {
    logic [WIDTH:0] sum;
    logic           id;
    logic           ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             res_valid, res_id, busy;
  logic             res_ready = 1'b0;
  logic [WIDTH:0]   res_sum;
`ifdef RCA_SEQ_ADD_SIGNED_OVF_EN
  logic             res_ovf;
`endif

  // single-word instance
  logic             n1_valid = 1'b0, n1_ready0, n1_ready1, n1_res_valid, n1_res_id, n1_busy;
  logic             n1_rr = 1'b0, n1_v1 = 1'b0;
  logic [WORD-1:0]  n1_a = '0, n1_b = '0, n1_z = '0;
  logic [WORD:0]    n1_sum;
`ifdef RCA_SEQ_ADD_SIGNED_OVF_EN
  logic             n1_ovf;
`endif

  rca_seq_add_ctrl #(.WORD(WORD), .NWORDS(NWORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_id(res_id),
    .busy(busy)
`ifdef RCA_SEQ_ADD_SIGNED_OVF_EN
    , .res_ovf(res_ovf)
`endif
  );

  rca_seq_add_ctrl #(.WORD(WORD), .NWORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(n1_valid), .req0_ready(n1_ready0), .req0_a(n1_a), .req0_b(n1_b),
    .req1_valid(n1_v1), .req1_ready(n1_ready1), .req1_a(n1_z), .req1_b(n1_z),
    .res_valid(n1_res_valid), .res_ready(n1_rr), .res_sum(n1_sum), .res_id(n1_res_id),
    .busy(n1_busy)
`ifdef RCA_SEQ_ADD_SIGNED_OVF_EN
    , .res_ovf(n1_ovf)
`endif
  );

  int   checks = 0;
  int   failures = 0;
  op_t  st_q0[$], st_q1[$];
  int   st_rd0 = 0, st_rd1 = 0;
  exp_t exp_q[$];
  int   exp_rd = 0;
  int   rr_mode = 1;           // 0 random res_ready, 1 always ready, 2 stalled

  int   m_phase = 0;           // 0 idle, 1 computing, 2 result pending
  int   m_cnt = 0;
  logic m_prio = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_val();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return WIDTH'(r[11:0]);
      default: return r[WIDTH-1:0];
    endcase
  endfunction

  // Reference model: arbitration decision and A+B result at acceptance, then timing.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      m_prio  = 1'b0;
    end else begin
      case (m_phase)
        0: if (req0_valid || req1_valid) begin
             logic g;
             logic [WIDTH-1:0] a, b;
             exp_t e;
             g = (req0_valid && req1_valid) ? m_prio : req1_valid;
             a = g ? req1_a : req0_a;
             b = g ? req1_b : req0_b;
             e.sum = {1'b0, a} + {1'b0, b};
             e.id  = g;
             e.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
             exp_q.push_back(e);
             m_prio  = !g;
             m_cnt   = NWORDS;
             m_phase = 1;
           end
        1: begin
             m_cnt--;
             if (m_cnt == 0) m_phase = 2;
           end
        default: if (res_ready) m_phase = 0;
      endcase
    end
  end

  // Monitor: handshake/timing checks each cycle, scoreboard compare on res_valid.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_sum", res_sum, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      exp_rd = exp_q.size();
    end else begin
      chk("req0_ready", req0_ready, (m_phase == 0) && req0_valid && !(req1_valid && m_prio));
      chk("req1_ready", req1_ready, (m_phase == 0) && req1_valid && !(req0_valid && !m_prio));
      chk("res_valid", res_valid, m_phase == 2);
      chk("busy", busy, m_phase != 0);
      if (res_valid) begin
        if (exp_rd >= exp_q.size()) begin
          chk("res_unexpected", res_valid, 0);
        end else begin
          chk("res_sum", res_sum, exp_q[exp_rd].sum);
          chk("res_id", res_id, exp_q[exp_rd].id);
`ifdef RCA_SEQ_ADD_SIGNED_OVF_EN
          chk("res_ovf", res_ovf, exp_q[exp_rd].ovf);
`endif
          if (res_ready) exp_rd++;
        end
      end
    end
  end

  // Requester and consumer drivers; inputs change 1 time unit after the clock edge.
  initial forever begin
    logic hs0, hs1;
    @(negedge clk);
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
    if (hs0) begin req0_valid = 1'b0; st_rd0++; end
    if (hs1) begin req1_valid = 1'b0; st_rd1++; end
    if (!req0_valid && st_rd0 < st_q0.size()) begin
      req0_a = st_q0[st_rd0].a; req0_b = st_q0[st_rd0].b; req0_valid = 1'b1;
    end
    if (!req1_valid && st_rd1 < st_q1.size()) begin
      req1_a = st_q1[st_rd1].a; req1_b = st_q1[st_rd1].b; req1_valid = 1'b1;
    end
    res_ready = (rr_mode == 0) ? 1'($urandom_range(0, 1)) : (rr_mode == 1);
  end

  task automatic wait_drain(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      done = (st_rd0 == st_q0.size()) && (st_rd1 == st_q1.size()) && !req0_valid &&
             !req1_valid && (m_phase == 0) && (exp_rd == exp_q.size());
    end
    chk("drain", done, 1);
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single op with full carry propagation, plus signed-overflow corners
    st_q0.push_back('{a: 48'hFFFF_FFFF_FFFF, b: 48'h1});
    wait_drain(100);
    st_q0.push_back('{a: 48'h7FFF_FFFF_FFFF, b: 48'h1});
    st_q0.push_back('{a: 48'hFFFF_FFFF_FFFF, b: 48'h1});
    wait_drain(100);

    // simultaneous requests, then req1 alone back to back
    st_q0.push_back('{a: 48'd5, b: 48'd7});
    st_q1.push_back('{a: 48'h800, b: 48'h800});
    wait_drain(100);
    for (int i = 0; i < 3; i++) st_q1.push_back('{a: rnd_val(), b: rnd_val()});
    wait_drain(200);

    // backpressure held in DONE while both requesters wait
    rr_mode = 2;
    st_q0.push_back('{a: rnd_val(), b: rnd_val()});
    st_q1.push_back('{a: rnd_val(), b: rnd_val()});
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = res_valid;
    end
    chk("bp_res_valid_seen", seen, 1);
    repeat (10) @(negedge clk);
    rr_mode = 1;
    wait_drain(200);

    // randomized traffic with random consumer stalls
    rr_mode = 0;
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(0, 2);
      if (sel != 1) st_q0.push_back('{a: rnd_val(), b: rnd_val()});
      if (sel != 0) st_q1.push_back('{a: rnd_val(), b: rnd_val()});
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    wait_drain(3000);
    rr_mode = 1;

    // reset at word index 2, then a tie must go to requester 0
    st_q0.push_back('{a: rnd_val(), b: rnd_val()});
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = busy;
    end
    chk("mid_busy_seen", seen, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res_sum", res_sum, 0);
    chk("mid_rst_res_id", res_id, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    st_q0.push_back('{a: rnd_val(), b: rnd_val()});
    st_q1.push_back('{a: rnd_val(), b: rnd_val()});
    wait_drain(100);

    // NWORDS = 1 instance
    @(posedge clk);
    #1 n1_a = 12'hFFF; n1_b = 12'hFFF; n1_valid = 1'b1; n1_rr = 1'b0;
    @(negedge clk);
    chk("n1_ready", n1_ready0, 1);
    @(posedge clk);
    #1 n1_valid = 1'b0;
    @(negedge clk);
    chk("n1_valid_run", n1_res_valid, 0);
    chk("n1_busy_run", n1_busy, 1);
    @(negedge clk);
    chk("n1_valid_done", n1_res_valid, 1);
    chk("n1_sum", n1_sum, 13'h1FFE);
    chk("n1_id", n1_res_id, 0);
`ifdef RCA_SEQ_ADD_SIGNED_OVF_EN
    chk("n1_ovf", n1_ovf, 0);
`endif
    @(posedge clk);
    #1 n1_rr = 1'b1;
    @(posedge clk);
    #1 n1_rr = 1'b0;
    @(negedge clk);
    chk("n1_idle", n1_busy, 0);
    chk("n1_valid_clr", n1_res_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rca_seq_add_ctrl.md
Name: rca_seq_add_ctrl

Overview:
- Two-requester scheduler that shares one WORD-bit ripple-carry adder slice (full-adder chain with carry-in) to perform WIDTH = WORD*NWORDS-bit unsigned additions, one word per cycle, least-significant word first.
- Sits between operand producers and the arithmetic datapath.
- Provides round-robin arbitration, valid/ready handshakes on both sides, and a carry register that chains the slices.

Parameters:
- WORD, 12, bit width of the shared adder slice.
- NWORDS, 4, number of slices per operation (≥1); WIDTH = WORD*NWORDS.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req1_valid / req1_ready / req1_a / req1_b  same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_sum  out  WIDTH+1  A+B; MSB is the final carry.
- res_id  out  1  index of the requester that owns the result.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; FSM = IDLE; operand/sum registers, carry, word index = 0; round-robin pointer gives requester 0 priority.
- FSM states: IDLE, RUN, DONE.
- IDLE, grant:
  - reqN_ready is combinational and asserted only for the granted requester.
  - One valid requester: it is granted.
  - Both valid: grant goes to the requester not granted last (requester 0 after reset).
  - Neither valid: no ready asserted, stay IDLE.
- IDLE, acceptance (valid&&ready at a clock edge):
  - Capture A, B and the requester id.
  - Clear carry and word index to 0.
  - Update the round-robin pointer.
  - Go to RUN.
- RUN, per edge:
  - {carry, sum_word[idx]} = A_word[idx] + B_word[idx] + carry; idx increments.
  - After the edge with idx = NWORDS-1, go to DONE.
- Latency: res_valid rises exactly NWORDS cycles after the acceptance edge.
- DONE:
  - res_valid = 1.
  - res_sum = {carry, sum_word[NWORDS-1..0]}; res_id = captured id.
  - res_sum and res_id stay stable while res_ready = 0.
  - On res_valid&&res_ready: go to IDLE and clear res_valid. A new request can be accepted on the next cycle; operations never overlap.
- Backpressure: a request valid during RUN or DONE waits with ready = 0. Requesters must hold valid and operands stable until ready.
- Wrap-around: the carry out of the top word goes only to res_sum[WIDTH]; there is no modulo truncation.
- Reset mid-operation (RUN or DONE): abort immediately, no result is emitted, all state returns to reset values.
- NWORDS = 1: RUN lasts one cycle, latency 1.

Optional Feature:
- Macro: RCA_SEQ_ADD_SIGNED_OVF_EN.
- Defined:
  - Adds output port res_ovf (1 bit), valid with res_valid.
  - res_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]), i.e. two's-complement overflow.
  - The operand sign bits are captured at acceptance.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single op, defaults:
  - Stimulus: req0 A=0xFFFFFFFFFFFF, B=0x000000000001.
  - Response: res_sum=0x1000000000000, res_id=0, res_valid rises 4 cycles after acceptance.
- Simultaneous requests right after reset:
  - Stimulus: req0 A=5, B=7 and req1 A=0x800, B=0x800, both valid, res_ready held 1.
  - Response: first result sum=12, id=0; second result sum=0x1000, id=1. Then three more back-to-back req1 ops with req0 idle are all granted to req1.
- Backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles in DONE.
  - Response: res_sum/res_id stable, req0_ready=req1_ready=0 throughout; IDLE entered 1 cycle after res_ready=1.
- Reset mid-RUN:
  - Stimulus: deassert rst_n at idx=2.
  - Response: all outputs 0 asynchronously, no res_valid after release; the next request from requester 0 wins a tie.
- With RCA_SEQ_ADD_SIGNED_OVF_EN:
  - A=0x7FFFFFFFFFFF, B=1 → res_ovf=1, res_sum=0x0800000000000.
  - A=0xFFFFFFFFFFFF, B=1 → res_ovf=0.
- NWORDS=1:
  - Stimulus: A=0xFFF, B=0xFFF.
  - Response: res_sum=0x1FFE, res_valid 1 cycle after acceptance.
